input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 23 ++
 rtl/input_conditioner_debouncer.sv | 114 +++++++++++
 rtl/input_conditioner.sv | 99 +++++++++
 tb/tb_input_conditioner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// input_conditioner_pkg
//
// Shared definitions for the input conditioner slice:
//   - deb_state_e          : debounce FSM state encoding used by debouncer
//   - DEF_DEBOUNCE_CYCLES  : default stable-cycle count before a new level is
//                            accepted (50000 cycles = 1 ms at 50 MHz)
//   - DEF_TICK_DIV         : default clk cycles between enable pulses
//                            (50000000 cycles = 1 s at 50 MHz)
// ----------------------------------------------------------------------------
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_TICK_DIV        = 50000000;

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_debouncer.sv
// ----------------------------------------------------------------------------
// debouncer
//
// Brings one raw asynchronous input into the clk domain through a 2-flop
// synchronizer, then filters it with a 4-state debounce FSM. A new level is
// accepted only after the synchronized input has shown it for
// DEBOUNCE_CYCLES consecutive cycles; any reversion during the wait returns
// to the previous stable state without touching the output.
//
// Latency: a raw change that stays put is reflected on 'level' exactly
// 2 + DEBOUNCE_CYCLES rising edges later (2 synchronizer edges, then
// DEBOUNCE_CYCLES FSM edges, the first of which is the STABLE->WAIT step).
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronized cycles required (>= 2)
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active low
//   raw   : raw asynchronous input
//   level : debounced level, registered
// ----------------------------------------------------------------------------
module debouncer
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    // The STABLE->WAIT transition cycle already counts as the first stable
    // cycle, so the wait ends when the counter has seen DEBOUNCE_CYCLES-2
    // further increments and the input still holds on the next edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             meta_p0;
    logic             sync_p1;
    deb_state_e       state;
    logic [CNT_W-1:0] cnt;

    // ---- stage p0/p1: two-flop synchronizer ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= raw;
            sync_p1 <= meta_p0;
        end
    end

    // ---- stage p2: debounce FSM with registered level ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (state)
                STABLE_LO: begin
                    if (sync_p1) begin
                        state <= WAIT_HI;
                        cnt   <= '0;
                    end
                end

                WAIT_HI: begin
                    if (!sync_p1) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STABLE_HI: begin
                    if (!sync_p1) begin
                        state <= WAIT_LO;
                        cnt   <= '0;
                    end
                end

                WAIT_LO: begin
                    if (sync_p1) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule : debouncer

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner
//
// Conditions a run/stop push-button and a direction switch for a downstream
// counter. Each raw input is synchronized and debounced by its own debouncer.
// Every accepted press of the button toggles run/stop; while running, a
// divider produces a one-cycle enable pulse every TICK_DIV clk cycles.
//
// Timing (relative to the edge where run_o rises): first enable_o pulse is
// TICK_DIV edges later, then every TICK_DIV edges. Stopping clears the
// divider; a stop that lands on the terminal-count edge swallows that pulse.
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized cycles to accept a level (>= 2)
//   TICK_DIV        : clk cycles between enable pulses while running (>= 2)
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active low
//   btn_i    : raw run/stop push-button, high = pressed
//   dir_sw_i : raw direction switch
//   enable_o : one-cycle count-enable pulse
//   dir_o    : debounced direction level
//   run_o    : run/stop status, 1 = running
// ----------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic dir_sw_i,
    output logic enable_o,
    output logic dir_o,
    output logic run_o
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic              btn_level;
    logic              btn_level_d;
    logic              btn_rise;
    logic              stop_req;
    logic              tick_last;
    logic [TICK_W-1:0] tick_cnt;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_i),
        .level (btn_level)
    );

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dir_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (dir_sw_i),
        .level (dir_o)
    );

    // The debounced level only rises on STABLE_HI entry, so a rising edge of
    // it marks exactly one accepted press; releases never produce a pulse.
    assign btn_rise  = btn_level & ~btn_level_d;
    assign stop_req  = btn_rise & run_o;
    assign tick_last = (tick_cnt == TICK_LAST);

    // ---- stage p3: run toggle, tick divider and enable pulse ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_level_d <= 1'b0;
            run_o       <= 1'b0;
            tick_cnt    <= '0;
            enable_o    <= 1'b0;
        end else begin
            btn_level_d <= btn_level;
            run_o       <= run_o ^ btn_rise;

            // A stop on the terminal-count edge wins over the pulse.
            enable_o <= run_o & ~stop_req & tick_last;

            // Divider idles at 0 when stopped so the first pulse after a
            // start arrives a full TICK_DIV cycles after run_o rises.
            if (!run_o || stop_req || tick_last) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int DEB  = 4;
    localparam int TDIV = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn_i    = 1'b0;
    logic dir_sw_i = 1'b0;
    logic enable_o;
    logic dir_o;
    logic run_o;

    int total = 0;
    int bad   = 0;
    int ec    = 0;
    int base  = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_DIV        (TDIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_i),
        .dir_sw_i (dir_sw_i),
        .enable_o (enable_o),
        .dir_o    (dir_o),
        .run_o    (run_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic want);
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, ec, obs, want);
        end
    endtask

    initial begin
        // Asynchronous reset with no clock edge yet.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("rst_enable", enable_o, 1'b0);
        chk("rst_dir", dir_o, 1'b0);
        chk("rst_run", run_o, 1'b0);
        chk("rst_tick", dut.tick_cnt == '0, 1'b1);

        step();
        step();
        rst = 1'b1;
        step();

        // Clean press from idle: run at edge 7, enables at 12, 17, 22.
        ec    = 0;
        btn_i = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step();
            chk("t1_run", run_o, ec >= 7);
            chk("t1_en", enable_o, (ec == 12) || (ec == 17) || (ec == 22));
            if (ec == 20) btn_i = 1'b0;
        end

        // Second clean press while running (press after 29 -> stop at 36).
        while (ec < 29) begin
            step();
            chk("t2_run_pre", run_o, 1'b1);
            chk("t2_en_pre", enable_o, ec == 27);
        end
        btn_i = 1'b1;
        while (ec < 47) begin
            step();
            chk("t2_run", run_o, ec < 36);
            chk("t2_en", enable_o, ec == 32);
            if (ec >= 36 && ec <= 40) chk("t2_tick_zero", dut.tick_cnt == '0, 1'b1);
            if (ec == 40) btn_i = 1'b0;
        end

        // Restart, then stop exactly on the terminal-count edge (74).
        btn_i = 1'b1;
        while (ec < 80) begin
            step();
            chk("t3_run", run_o, (ec >= 54) && (ec < 74));
            chk("t3_en", enable_o, (ec == 59) || (ec == 64) || (ec == 69));
            if (ec == 74) chk("t3_tick_zero", dut.tick_cnt == '0, 1'b1);
            if (ec == 57) btn_i = 1'b0;
            if (ec == 67) btn_i = 1'b1;
            if (ec == 77) btn_i = 1'b0;
        end

        // Direction switch: 2-cycle glitch ignored, clean rise after 90 -> dir at 96.
        dir_sw_i = 1'b1;
        while (ec < 97) begin
            step();
            if (ec == 82) dir_sw_i = 1'b0;
            if (ec == 90) dir_sw_i = 1'b1;
            chk("t4_dir", dir_o, ec >= 96);
            chk("t4_run", run_o, 1'b0);
        end

        // Bouncy button: 3 high / 1 low for 40 cycles never gets accepted.
        for (int k = 0; k < 40; k++) begin
            btn_i = ((k % 4) != 3);
            step();
            chk("t5_run", run_o, 1'b0);
            chk("t5_en", enable_o, 1'b0);
        end
        btn_i = 1'b0;
        repeat (6) step();
        chk("t5_run_end", run_o, 1'b0);

        // Run again (press after 143 -> run at 150, enable at 155), then reset mid-tick.
        btn_i = 1'b1;
        while (ec < 157) begin
            step();
            chk("t6_run", run_o, ec >= 150);
            chk("t6_en", enable_o, ec == 155);
            if (ec == 153) btn_i = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_en", enable_o, 1'b0);
        chk("t6_rst_run", run_o, 1'b0);
        chk("t6_rst_dir", dir_o, 1'b0);
        chk("t6_rst_tick", dut.tick_cnt == '0, 1'b1);
        step();
        chk("t6_rst_hold_run", run_o, 1'b0);
        rst  = 1'b1;
        base = ec;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t6_post_en", enable_o, 1'b0);
            chk("t6_post_run", run_o, 1'b0);
            chk("t6_post_dir", dir_o, (ec - base) >= 6);
        end

        // Button held through reset release counts as a new press.
        rst   = 1'b0;
        btn_i = 1'b1;
        step();
        step();
        chk("t7_rst_run", run_o, 1'b0);
        chk("t7_rst_en", enable_o, 1'b0);
        rst  = 1'b1;
        base = ec;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t7_run", run_o, (ec - base) >= 7);
            chk("t7_en", enable_o, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_input_conditioner
